// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_stage_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  typedef enum logic [6:0] {
    LOAD     = 7'h03,
    MISC_MEM = 7'h0F,
    OPIMM    = 7'h13,
    AUIPC    = 7'h17,
    STORE    = 7'h23,
    OP       = 7'h33,
    LUI      = 7'h37,
    BRANCH   = 7'h63,
    JALR     = 7'h67,
    JAL      = 7'h6F,
    SYSTEM   = 7'h73
  } opcodes_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'h0000_0004;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer with synchronous flush; head is read combinationally from storage.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     push_data,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  entry_t        mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;
  logic          full_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == CNT_FULL);
  assign do_push_s = push & ~flush;
  assign do_pop_s  = pop & ~flush & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Data storage; visibility is governed by count, so entries need no reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  fetch_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (do_pop_s),
    .flush (flush),
    .full  (full_s)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Protocol checker for the fetch instruction buffer.
module fetch_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic flush,
  input logic full
);

  // The fetch credit scheme must never push into a full buffer without a matching pop
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: sequential PC generation, credit-limited imem requests,
// response buffering and decode-field split of the buffer head.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output opcodes_t    opcode,
  output logic [2:0]  f3,
  output logic        f7,
  output logic [24:0] immSample
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [SW-1:0] DEPTH_W = SW'(FIFO_DEPTH);

  fetch_state_t  state_r;
  fetch_state_t  state_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   rsp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;
  logic          pending_r;

  logic [CW-1:0] fifo_count_s;
  logic          fifo_empty_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_entry_s;
  logic [CW-1:0] rsp_dec_s;
  logic [SW-1:0] committed_s;
  logic          credit_s;
  logic          req_valid_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;

  assign pop_s        = if_valid & if_ready & ~redirect_valid;
  assign drop_s       = imem_rsp_valid & (drop_cnt_r != {CW{1'b0}});
  assign push_s       = imem_rsp_valid & (drop_cnt_r == {CW{1'b0}}) & ~redirect_valid;
  assign accept_s     = req_valid_s & imem_req_ready;
  assign rsp_dec_s    = {{(CW-1){1'b0}}, imem_rsp_valid};
  assign push_entry_s = '{pc: rsp_pc_r, instr: imem_rdata};

  // A slot freed by this cycle's pop is reusable at once, which sustains 1 instr/cycle
  assign committed_s = SW'(outstanding_r) + SW'(fifo_count_s) - SW'(pop_s);
  assign credit_s    = (committed_s < DEPTH_W);

  // Next state and request generation; an unaccepted request is held regardless of fetch_en
  always_comb begin
    state_s     = state_r;
    req_valid_s = 1'b0;
    case (state_r)
      BOOT: begin
        state_s     = FETCH;
        req_valid_s = 1'b0;
      end
      FETCH: begin
        state_s     = FETCH;
        req_valid_s = ~redirect_valid & (pending_r | (fetch_en & credit_s));
      end
      default: begin
        state_s     = BOOT;
        req_valid_s = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_s;
    end
  end

  // PCs, in-flight and drop accounting; a redirect squashes everything still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
      pending_r     <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_r    <= align_pc(redirect_pc);
      rsp_pc_r      <= align_pc(redirect_pc);
      outstanding_r <= outstanding_r - rsp_dec_s;
      drop_cnt_r    <= outstanding_r - rsp_dec_s;
      pending_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      if (push_s) begin
        rsp_pc_r <= rsp_pc_r + PC_STEP;
      end
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r - CNT_ONE;
      end
      case ({accept_s, imem_rsp_valid})
        2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
        2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
        default: outstanding_r <= outstanding_r;
      endcase
      pending_r <= req_valid_s & ~imem_req_ready;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .push_data (push_entry_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  assign imem_req_valid = req_valid_s;
  assign imem_addr      = fetch_pc_r;
  assign if_valid       = ~fifo_empty_s;
  assign if_pc          = if_valid ? head_s.pc    : 32'h0000_0000;
  assign if_instr       = if_valid ? head_s.instr : 32'h0000_0000;
  assign opcode         = opcodes_t'(if_instr[6:0]);
  assign f3             = if_instr[14:12];
  assign f7             = if_instr[30];
  assign immSample      = if_instr[31:7];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order memory model with random latency,
// epoch-tagged requests to model redirect squashing, and a decode-side monitor.
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst, fetch_en, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, if_valid, if_ready, f7;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_pc, if_instr;
  logic [2:0]  f3;
  logic [24:0] immSample;
  opcodes_t    opcode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .opcode(opcode), .f3(f3), .f7(f7), .immSample(immSample)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_pc;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           epoch = 0;
  logic [31:0]  model_pc;
  bit           c_rst, c_fen, c_ifr, c_rdy, c_redir;
  logic [31:0]  c_rpc;
  int           c_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, memory answers in order, log acceptance mid-cycle
  task automatic step();
    mreq_t e;
    int    lat;
    int    due;
    @(posedge clk);
    #1;
    cyc++;
    rst            = c_rst;
    fetch_en       = c_fen;
    if_ready       = c_ifr;
    imem_req_ready = c_rdy;
    redirect_valid = c_redir;
    redirect_pc    = c_rpc;
    c_redir        = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = 32'h0;
    if (c_rst) begin
      mem_q.delete();
      exp_q.delete();
      model_pc = RST_PC;
      epoch++;
    end else begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        e = mem_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rdata     = mem_word(e.addr);
        if (e.epoch == epoch && !redirect_valid)
          exp_q.push_back('{pc: e.exp_pc, instr: mem_word(e.exp_pc)});
      end
      if (redirect_valid) begin
        epoch++;
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end
    end
    @(negedge clk);
    if (!rst && redirect_valid) check("redir_noreq", 32'(imem_req_valid), 32'h0);
    if (!rst && imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_addr, model_pc);
      lat = (c_lat > 0) ? c_lat : int'($urandom_range(1, 3));
      due = cyc + lat;
      if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
      mem_q.push_back('{addr: imem_addr, exp_pc: model_pc, epoch: epoch, due: due});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    c_rst   = 1'b1;
    c_redir = 1'b0;
    repeat (2) step();
    c_rst = 1'b0;
  endtask

  // Monitor: compare every decode handshake against the scoreboard head
  initial begin
    fetch_entry_t exp_e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      if (if_valid && if_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious: if_pc %h presented, scoreboard empty (cycle %0d)", if_pc, cyc);
        end else begin
          exp_e = exp_q.pop_front();
          check("if_pc", if_pc, exp_e.pc);
          check("if_instr", if_instr, exp_e.instr);
          check("opcode", 32'(opcode), 32'(exp_e.instr[6:0]));
          check("f3", 32'(f3), 32'(exp_e.instr[14:12]));
          check("f7", 32'(f7), 32'(exp_e.instr[30]));
          check("immSample", 32'(immSample), 32'(exp_e.instr[31:7]));
        end
      end else if (!if_valid) begin
        check("idle_zero", if_pc | if_instr, 32'h0);
      end
    end
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
    c_rst = 1'b1; c_fen = 1'b1; c_ifr = 1'b1; c_rdy = 1'b1; c_redir = 1'b0;
    c_rpc = 32'h0; c_lat = 1; model_pc = RST_PC;

    // Reset, boot cycle, first addresses and the pre-split head fields
    step(); step();
    check("rst_req", 32'(imem_req_valid), 32'h0);
    check("rst_ifv", 32'(if_valid), 32'h0);
    check("rst_pc", if_pc, 32'h0);
    c_rst = 1'b0;
    step();
    check("boot_noreq", 32'(imem_req_valid), 32'h0);
    step();
    check("t1_v0", 32'(imem_req_valid), 32'h1);
    check("t1_a0", imem_addr, 32'h100);
    step();
    check("t1_a1", imem_addr, 32'h104);
    check("no_bypass", 32'(if_valid), 32'h0);
    step();
    check("t1_a2", imem_addr, 32'h108);
    check("lat_ifv", 32'(if_valid), 32'h1);
    check("t2_pc", if_pc, 32'h100);
    check("t2_opc", 32'(opcode), 32'(OPIMM));
    check("t2_f3", 32'(f3), 32'h0);
    check("t2_f7", 32'(f7), 32'h0);
    check("t2_imm", 32'(immSample), 32'h00A001);
    repeat (6) step();

    // Backpressure: buffer plus in-flight saturate, head holds
    c_ifr = 1'b0;
    do_reset();
    repeat (7) step();
    check("bp_noreq", 32'(imem_req_valid), 32'h0);
    check("bp_valid", 32'(if_valid), 32'h1);
    check("bp_head", if_pc, 32'h100);
    c_ifr = 1'b1;
    repeat (8) step();

    // Redirect with two requests still in flight
    c_lat = 3;
    do_reset();
    repeat (3) step();
    c_redir = 1'b1; c_rpc = 32'h203;
    step();
    for (int i = 0; i < 10 && !imem_req_valid; i++) step();
    check("t4_req", 32'(imem_req_valid), 32'h1);
    check("t4_addr", imem_addr, 32'h200);
    for (int i = 0; i < 12 && !if_valid; i++) step();
    check("t4_ifpc", if_pc, 32'h200);
    repeat (4) step();

    // Redirect coinciding with a response and a pop
    c_lat = 1;
    do_reset();
    repeat (6) step();
    c_redir = 1'b1; c_rpc = 32'h400;
    step();
    check("t5_ifv_ungated", 32'(if_valid), 32'h1);
    step();
    check("t5_flushed", 32'(if_valid), 32'h0);
    check("t5_req", 32'(imem_req_valid), 32'h1);
    check("t5_addr", imem_addr, 32'h400);
    repeat (5) step();

    // Stalled memory with fetch_en toggling: request held, then no new issue
    do_reset();
    repeat (4) step();
    c_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_fen = (i % 2 == 0);
      step();
      check("t6_hold_v", 32'(imem_req_valid), 32'h1);
      check("t6_hold_a", imem_addr, 32'h10C);
    end
    c_rdy = 1'b1; c_fen = 1'b0;
    step();
    check("t6_acc", 32'(imem_req_valid), 32'h1);
    repeat (3) begin
      step();
      check("t6_idle", 32'(imem_req_valid), 32'h0);
    end
    c_fen = 1'b1;
    repeat (6) step();

    // Reset wins over a simultaneous redirect
    c_rst = 1'b1; c_redir = 1'b1; c_rpc = 32'h800;
    step();
    c_rst = 1'b0;
    step();
    check("rr_boot", 32'(imem_req_valid), 32'h0);
    step();
    check("rr_addr", imem_addr, RST_PC);

    // Random traffic, redirects (including near address wrap)
    c_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      c_ifr = ($urandom_range(0, 9) < 7);
      c_rdy = ($urandom_range(0, 9) < 7);
      c_fen = ($urandom_range(0, 9) < 9);
      if ($urandom_range(0, 99) < 4) begin
        c_redir = 1'b1;
        c_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      end
      step();
    end

    // Drain: everything fetched must have been delivered
    c_fen = 1'b0; c_ifr = 1'b1; c_rdy = 1'b1; c_redir = 1'b0;
    repeat (20) step();
    check("drain_sb", 32'(exp_q.size()), 32'h0);
    check("drain_mem", 32'(mem_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
